// File: rtl/barcode_stream_decoder.sv
// rtl/barcode_stream_decoder.sv - serial Code128-C decoder: hunts the start symbol, then decodes N_FIELDS symbols.
// Optional macro BARCODE_STOP_CHECK_EN adds a STOP state that requires and checks the 13-bit stop symbol.
module barcode_stream_decoder #(
    parameter int N_FIELDS   = 3,
    parameter int FIELD_W    = 8,
    parameter int MAX_SEARCH = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_bit_valid,
    input  logic                        i_bit,
    output logic [N_FIELDS*FIELD_W-1:0] o_fields,
    output logic                        o_done,
    output logic [1:0]                  o_error,
    output logic                        o_busy
);
    localparam logic [10:0] START_SYM   = 11'b11010011100;
    localparam int          CNT_W       = $clog2(MAX_SEARCH + 1);
    localparam logic [1:0]  ERR_OK      = 2'd0;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]  ERR_SYM     = 2'd2;
`ifdef BARCODE_STOP_CHECK_EN
    localparam int          SH_W        = 13;
    localparam logic [1:0]  ERR_STOP    = 2'd3;
    localparam logic [12:0] STOP_SYM    = 13'b1100011101011;
`else
    // Only the stop check ever looks at more than one symbol's worth of bits.
    localparam int          SH_W        = 11;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_COLLECT, S_STOP, S_DONE} state_t;

    state_t            state;
    logic [SH_W-1:0]   shreg;
    logic [SH_W-1:0]   sh_next;
    logic [CNT_W-1:0]  search_cnt;
    logic [3:0]        sym_bit_cnt;
    logic [3:0]        field_idx;
    logic              bad_sym;
    logic              sym_ok;
    logic [3:0]        sym_digit;

    assign sh_next = {shreg[SH_W-2:0], i_bit};

    always_comb begin
        sym_ok    = 1'b1;
        sym_digit = 4'd0;
        case (sh_next[10:0])
            11'b11011001100: sym_digit = 4'd0;
            11'b11001101100: sym_digit = 4'd1;
            11'b11001100110: sym_digit = 4'd2;
            11'b10010011000: sym_digit = 4'd3;
            11'b10010001100: sym_digit = 4'd4;
            11'b10001001100: sym_digit = 4'd5;
            11'b10011001000: sym_digit = 4'd6;
            11'b10011000100: sym_digit = 4'd7;
            11'b10001100100: sym_digit = 4'd8;
            11'b11001001000: sym_digit = 4'd9;
            default:         sym_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            search_cnt  <= '0;
            sym_bit_cnt <= '0;
            field_idx   <= '0;
            bad_sym     <= 1'b0;
            o_fields    <= '0;
            o_done      <= 1'b0;
            o_error     <= ERR_OK;
            o_busy      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        // Clearing the shifter keeps stale bits from faking a start match.
                        state       <= S_SEARCH;
                        shreg       <= '0;
                        search_cnt  <= '0;
                        sym_bit_cnt <= '0;
                        field_idx   <= '0;
                        bad_sym     <= 1'b0;
                        o_fields    <= '0;
                        o_error     <= ERR_OK;
                        o_busy      <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (i_bit_valid) begin
                        shreg      <= sh_next;
                        search_cnt <= search_cnt + 1'b1;
                        if (sh_next[10:0] == START_SYM) begin
                            state       <= S_COLLECT;
                            sym_bit_cnt <= '0;
                            field_idx   <= '0;
                        end else if (search_cnt == CNT_W'(MAX_SEARCH - 1)) begin
                            state   <= S_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            o_error <= ERR_TIMEOUT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (i_bit_valid) begin
                        shreg <= sh_next;
                        if (sym_bit_cnt == 4'd10) begin
                            sym_bit_cnt <= '0;
                            field_idx   <= field_idx + 1'b1;
                            o_fields[field_idx*FIELD_W +: FIELD_W] <=
                                sym_ok ? FIELD_W'(sym_digit) : {FIELD_W{1'b1}};
                            if (!sym_ok)
                                bad_sym <= 1'b1;
                            if (field_idx == 4'(N_FIELDS - 1)) begin
`ifdef BARCODE_STOP_CHECK_EN
                                state <= S_STOP;
`else
                                state   <= S_DONE;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                                o_error <= (bad_sym || !sym_ok) ? ERR_SYM : ERR_OK;
`endif
                            end
                        end else begin
                            sym_bit_cnt <= sym_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef BARCODE_STOP_CHECK_EN
                S_STOP: begin
                    // sym_bit_cnt is reused here to count the 13 stop modules.
                    if (i_bit_valid) begin
                        shreg <= sh_next;
                        if (sym_bit_cnt == 4'd12) begin
                            state   <= S_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            if (bad_sym)
                                o_error <= ERR_SYM;
                            else if (sh_next != STOP_SYM)
                                o_error <= ERR_STOP;
                            else
                                o_error <= ERR_OK;
                        end else begin
                            sym_bit_cnt <= sym_bit_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_barcode_stream_decoder.sv
// tb/tb_barcode_stream_decoder.sv - self-checking bench for barcode_stream_decoder.
// Expectations follow BARCODE_STOP_CHECK_EN the same way the design does.
module tb_barcode_stream_decoder;
    localparam int N_FIELDS   = 3;
    localparam int FIELD_W    = 8;
    localparam int MAX_SEARCH = 256;
    localparam int FW         = N_FIELDS * FIELD_W;
    localparam logic [12:0] START_SYM = 13'b0011010011100;
    localparam logic [12:0] STOP_SYM  = 13'b1100011101011;
`ifdef BARCODE_STOP_CHECK_EN
    localparam bit STOP_ON = 1'b1;
`else
    localparam bit STOP_ON = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
    logic [FW-1:0] fields;
    logic          done, busy;
    logic [1:0]    error;

    barcode_stream_decoder #(.N_FIELDS(N_FIELDS), .FIELD_W(FIELD_W), .MAX_SEARCH(MAX_SEARCH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bit_valid(bit_valid), .i_bit(bit_in),
        .o_fields(fields), .o_done(done), .o_error(error), .o_busy(busy)
    );

    always #5 clk = ~clk;

    logic [10:0] code_c [10] = '{11'b11011001100, 11'b11001101100, 11'b11001100110, 11'b10010011000,
                                 11'b10010001100, 11'b10001001100, 11'b10011001000, 11'b10011000100,
                                 11'b10001100100, 11'b11001001000};

    bit            stream[$];
    int            n_checks = 0, n_fail = 0, acc;
    logic [FW-1:0] obs_fields, exp_fields;
    logic [1:0]    obs_err, exp_err;
    int            obs_done_n, obs_done_idx, exp_idx;

    task automatic push(input logic [12:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endtask

    function automatic logic [12:0] window(input int p, input int n);
        logic [12:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[11:0], stream[p+i]};
        return w;
    endfunction

    // Reference: scan the accepted-bit sequence for the start pattern, then slice fixed-size symbols.
    function automatic void model();
        int pos = -1;
        int d;
        bit bad = 1'b0;
        exp_fields = '0; exp_err = 2'd0; exp_idx = -2;
        for (int i = 10; i < stream.size() && i < MAX_SEARCH; i++)
            if (window(i - 10, 11) == START_SYM) begin pos = i + 1; break; end
        if (pos < 0) begin
            if (stream.size() >= MAX_SEARCH) begin exp_err = 2'd1; exp_idx = MAX_SEARCH - 1; end
            return;
        end
        for (int k = 0; k < N_FIELDS; k++) begin
            d = -1;
            for (int c = 0; c < 10; c++) if (window(pos, 11) == 13'(code_c[c])) d = c;
            if (d < 0) begin bad = 1'b1; exp_fields[k*FIELD_W +: FIELD_W] = '1; end
            else exp_fields[k*FIELD_W +: FIELD_W] = FIELD_W'(d);
            pos += 11;
        end
        exp_err = bad ? 2'd2 : 2'd0;
        exp_idx = pos - 1;
        if (STOP_ON) begin
            exp_idx = pos + 12;
            if (!bad && window(pos, 13) != STOP_SYM) exp_err = 2'd3;
        end
        if (exp_idx >= stream.size()) exp_idx = -2;
    endfunction

    task automatic tick(input bit accepted);
        @(posedge clk); #1;
        if (accepted) acc++;
        if (done) begin
            obs_done_n++;
            if (obs_done_n == 1) begin
                obs_done_idx = accepted ? acc - 1 : -1;
                obs_fields   = fields;
                obs_err      = error;
            end
        end
    endtask

    task automatic drive(input bit gaps);
        int g;
        acc = 0; obs_done_n = 0; obs_done_idx = -2; obs_fields = '0; obs_err = 2'd0;
        for (int i = 0; i < stream.size(); i++) begin
            g = gaps ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < g; j++) begin
                bit_valid = 1'b0; bit_in = 1'($urandom); tick(1'b0);
            end
            bit_valid = 1'b1; bit_in = stream[i]; tick(1'b1);
        end
        bit_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick(1'b0);
    endtask

    task automatic do_start();
        start = 1'b1; bit_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic build_plan(input logic [10:0] sym1, input logic [12:0] stop);
        stream.delete();
        push(START_SYM, 11); push(13'(code_c[1]), 11); push(13'(sym1), 11); push(13'(code_c[3]), 11);
        push(stop, 13);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        n_checks++; if (fields !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", fields); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (error !== 2'd0) begin n_fail++; $display("FAIL reset_error: got %0d expected 0", error); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        build_plan(code_c[2], STOP_SYM);
        do_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        drive(1'b0);
        n_checks++; if (obs_fields !== 24'h030201) begin n_fail++; $display("FAIL basic_fields: got %h expected 030201", obs_fields); end
        n_checks++; if (obs_err !== 2'd0) begin n_fail++; $display("FAIL basic_error: got %0d expected 0", obs_err); end
        n_checks++; if (obs_done_idx !== (STOP_ON ? 56 : 43)) begin n_fail++; $display("FAIL basic_latency: done after bit %0d expected %0d", obs_done_idx, STOP_ON ? 56 : 43); end
        n_checks++; if (obs_done_n !== 1) begin n_fail++; $display("FAIL basic_pulse: done high %0d cycles expected 1", obs_done_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_gaps();
        build_plan(code_c[2], STOP_SYM);
        for (int i = 0; i < 5; i++) stream.push_front(1'b0);
        do_start();
        drive(1'b1);
        n_checks++; if (obs_fields !== 24'h030201) begin n_fail++; $display("FAIL gaps_fields: got %h expected 030201", obs_fields); end
        n_checks++; if (obs_done_idx !== (STOP_ON ? 61 : 48)) begin n_fail++; $display("FAIL gaps_latency: done after bit %0d expected %0d", obs_done_idx, STOP_ON ? 61 : 48); end
        n_checks++; if (obs_err !== 2'd0) begin n_fail++; $display("FAIL gaps_error: got %0d expected 0", obs_err); end
    endtask

    task automatic test_bad_symbol();
        build_plan(11'h7FF, STOP_SYM);
        do_start();
        drive(1'b0);
        n_checks++; if (obs_fields !== 24'h03FF01) begin n_fail++; $display("FAIL badsym_fields: got %h expected 03ff01", obs_fields); end
        n_checks++; if (obs_err !== 2'd2) begin n_fail++; $display("FAIL badsym_error: got %0d expected 2", obs_err); end
        n_checks++; if (error !== 2'd2) begin n_fail++; $display("FAIL badsym_error_held: got %0d expected 2", error); end
    endtask

    task automatic test_timeout();
        stream.delete();
        for (int i = 0; i < MAX_SEARCH; i++) stream.push_back(1'b0);
        do_start();
        drive(1'b0);
        n_checks++; if (obs_done_idx !== MAX_SEARCH - 1) begin n_fail++; $display("FAIL timeout_latency: done after bit %0d expected %0d", obs_done_idx, MAX_SEARCH - 1); end
        n_checks++; if (obs_err !== 2'd1) begin n_fail++; $display("FAIL timeout_error: got %0d expected 1", obs_err); end
        n_checks++; if (obs_fields !== '0) begin n_fail++; $display("FAIL timeout_fields: got %h expected 0", obs_fields); end
    endtask

    task automatic test_bad_stop();
        build_plan(code_c[2], 13'd0);
        do_start();
        drive(1'b0);
        n_checks++; if (obs_err !== (STOP_ON ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL badstop_error: got %0d expected %0d", obs_err, STOP_ON ? 3 : 0); end
        n_checks++; if (obs_done_idx !== (STOP_ON ? 56 : 43)) begin n_fail++; $display("FAIL badstop_latency: done after bit %0d expected %0d", obs_done_idx, STOP_ON ? 56 : 43); end
        n_checks++; if (error !== (STOP_ON ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL badstop_error_held: got %0d expected %0d", error, STOP_ON ? 3 : 0); end
    endtask

    task automatic test_reset_mid();
        stream.delete();
        push(START_SYM, 11); push(13'(code_c[1]), 11); push(13'b11001, 5);
        do_start();
        drive(1'b0);
        n_checks++; if (fields !== 24'h000001) begin n_fail++; $display("FAIL midrst_partial: got %h expected 000001", fields); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0; #2;
        n_checks++; if (fields !== '0) begin n_fail++; $display("FAIL midrst_fields: got %h expected 0", fields); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (error !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got err %0d done %b expected 0 0", error, done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        build_plan(code_c[2], STOP_SYM);
        drive(1'b0);
        n_checks++; if (obs_done_n !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got done %0d busy %b expected 0 0", obs_done_n, busy); end
    endtask

    task automatic test_start_in_search();
        stream.delete();
        for (int i = 0; i < 100; i++) stream.push_back(1'b0);
        do_start();
        drive(1'b0);
        do_start();
        stream.delete();
        for (int i = 0; i < MAX_SEARCH - 100; i++) stream.push_back(1'b0);
        drive(1'b0);
        n_checks++; if (obs_done_idx !== MAX_SEARCH - 101) begin n_fail++; $display("FAIL busy_start_latency: done after bit %0d expected %0d", obs_done_idx, MAX_SEARCH - 101); end
        n_checks++; if (obs_err !== 2'd1) begin n_fail++; $display("FAIL busy_start_error: got %0d expected 1", obs_err); end
    endtask

    task automatic test_random();
        int nlead, ntail;
        for (int it = 0; it < 30; it++) begin
            stream.delete();
            nlead = $urandom_range(0, 20);
            ntail = $urandom_range(0, 5);
            for (int i = 0; i < nlead; i++) stream.push_back(1'($urandom));
            push(START_SYM, 11);
            for (int k = 0; k < N_FIELDS; k++)
                if ($urandom_range(0, 4) == 0) push(13'($urandom), 11);
                else push(13'(code_c[$urandom_range(0, 9)]), 11);
            if ($urandom_range(0, 3) == 0) push(13'($urandom), 13);
            else push(STOP_SYM, 13);
            for (int i = 0; i < ntail; i++) stream.push_back(1'($urandom));
            model();
            do_start();
            drive(1'($urandom));
            n_checks++; if (obs_fields !== exp_fields) begin n_fail++; $display("FAIL rand%0d_fields: got %h expected %h", it, obs_fields, exp_fields); end
            n_checks++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_error: got %0d expected %0d", it, obs_err, exp_err); end
            n_checks++; if (obs_done_idx !== exp_idx) begin n_fail++; $display("FAIL rand%0d_latency: done after bit %0d expected %0d", it, obs_done_idx, exp_idx); end
            n_checks++; if (obs_done_n !== 1) begin n_fail++; $display("FAIL rand%0d_pulse: done high %0d cycles expected 1", it, obs_done_n); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bad_symbol();
        test_timeout();
        test_bad_stop();
        test_reset_mid();
        test_start_in_search();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
